// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one outstanding imem request, loads IF/ID.
// Response lands in IF/ID one cycle after imem_rvalid; stall_en parks a response in a skid buffer and holds IF/ID.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic [31:0] redirect_pc,
    input  logic        stall_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HELD = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } skid_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        kill, kill_n;
    skid_t       skid, skid_n;
    if_id_t      if_id, if_id_n;
    logic        req_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            kill  <= 1'b0;
            skid  <= '0;
            if_id <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            kill  <= kill_n;
            skid  <= skid_n;
            if_id <= if_id_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        kill_n        = kill;
        skid_n        = skid;
        if_id_n       = if_id;
        req_c         = 1'b0;
        // A free pipeline with nothing to load takes a bubble; a stalled one keeps its entry.
        if_id_n.valid = stall_en ? if_id.valid : 1'b0;

        if (branch) begin
            pc_n          = {redirect_pc[31:2], 2'b00};
            if_id_n.valid = 1'b0;
            unique case (state)
                S_IDLE: state_n = S_IDLE;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_n = S_IDLE;
                        kill_n  = 1'b0;
                    end else begin
                        kill_n  = 1'b1;
                    end
                end
                S_HELD:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end else begin
            unique case (state)
                S_IDLE: begin
                    req_c = !stall_en;
                    if (!stall_en) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            // Wrong-path response; pc already holds the redirect target.
                            kill_n  = 1'b0;
                            state_n = S_IDLE;
                        end else if (!stall_en) begin
                            if_id_n = '{valid: 1'b1, pc: pc, inst: imem_rdata};
                            pc_n    = pc + 32'd4;
                            state_n = S_IDLE;
                        end else begin
                            skid_n  = '{pc: pc, inst: imem_rdata};
                            state_n = S_HELD;
                        end
                    end
                end
                S_HELD: begin
                    if (!stall_en) begin
                        if_id_n = '{valid: 1'b1, pc: skid.pc, inst: skid.inst};
                        pc_n    = pc + 32'd4;
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign imem_req    = req_c && !rst;
    assign imem_addr   = pc;
    assign if_id_valid = if_id.valid;
    assign if_id_pc    = if_id.pc;
    assign if_id_inst  = if_id.inst;

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller: the consumer of the hazard unit's `branch` (redirect) and `stall_en` (hold) signals. It owns the PC, issues single-outstanding requests to instruction memory, and discards wrong-path responses after a redirect. It loads the IF/ID register with `{valid, pc, inst}`. It sits between the instruction memory port and the decode stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; low 2 bits must be 0.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `branch` in 1: redirect request from the hazard unit; takes priority over everything.
- `redirect_pc` in 32: target PC; sampled when `branch`=1; bits [1:0] are forced to 0.
- `stall_en` in 1: freezes the IF/ID register and blocks new requests.
- `imem_req` out 1: fetch request, asserted for one cycle per fetch.
- `imem_addr` out 32: fetch address; equals the current PC.
- `imem_rvalid` in 1: response valid; arrives 1 or more cycles after `imem_req`.
- `imem_rdata` in 32: instruction word, valid with `imem_rvalid`.
- `if_id_valid` out 1: IF/ID register holds a valid instruction.
- `if_id_pc` out 32: PC of the instruction in IF/ID.
- `if_id_inst` out 32: instruction in IF/ID.

## Operation
- FSM states: IDLE, WAIT, HELD. Registers: `pc`, `kill`, skid buffer `{skid_pc, skid_inst}`, and IF/ID.
- IDLE:
  - `imem_req` = !`stall_en` && !`branch` (combinational); `imem_addr` = `pc`.
  - On request, go to WAIT.
  - `imem_rvalid` in IDLE is ignored.
- WAIT, on `imem_rvalid`:
  - `kill`=1: drop the response, clear `kill`, go to IDLE. `pc` is unchanged; it already holds the redirect target.
  - `kill`=0 and `stall_en`=0: IF/ID <= {1, `pc`, `imem_rdata`}; `pc` <= `pc`+4; go to IDLE.
  - `kill`=0 and `stall_en`=1: capture into the skid buffer; go to HELD.
- HELD:
  - When `stall_en`=0: IF/ID <= {1, `skid_pc`, `skid_inst`}; `pc` <= `pc`+4; go to IDLE.
- IF/ID update rule:
  - `stall_en`=1 and no `branch`: IF/ID holds its contents.
  - `stall_en`=0 and nothing to load that cycle: `if_id_valid` <= 0 (bubble); `if_id_pc` and `if_id_inst` hold their values.
- `branch`=1 in any state:
  - `pc` <= `{redirect_pc[31:2], 2'b00}`; `if_id_valid` <= 0.
  - IDLE: no request this cycle; stay in IDLE.
  - WAIT without `imem_rvalid`: `kill` <= 1; stay in WAIT.
  - WAIT with `imem_rvalid` the same cycle: drop the response; go to IDLE with `kill`=0.
  - HELD: discard the skid buffer; go to IDLE.
- `branch` and `stall_en` together: `branch` wins; the flush and redirect happen regardless of the stall.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: `pc`=`RESET_PC`, state=IDLE, `kill`=0, `imem_req`=0 during reset, `imem_addr`=`RESET_PC`, `if_id_valid`=0, `if_id_pc`=0, `if_id_inst`=0, skid buffer=0.
- First `imem_req` is in the first cycle after `rst` deasserts, if `stall_en`=0.
- Load latency: response at cycle N lands in IF/ID visible at N+1. The next request issues at N+1.
- Throughput: at most one instruction per 2 cycles with 1-cycle memory latency. Only one request is ever outstanding.
- Redirect: `branch` at cycle N puts `imem_req` with `imem_addr`=target at N+1 when the FSM is IDLE. If a killed fetch is pending, the request waits for its response plus one cycle.
- Reset mid-operation: all state returns to reset values immediately. A response still in flight from before the reset arrives while the FSM is IDLE and is ignored.

## Test plan
- Reset release with RESET_PC=0x100, memory latency 1, no stall:
  - `imem_req` at cycles 1, 3, 5 with addresses 0x100, 0x104, 0x108.
  - IF/ID valid at cycles 3, 5, 7 with the matching PC and inst.
- Redirect while WAIT, memory latency 3: `branch`=1 with `redirect_pc`=0x203 one cycle after the request to 0x104.
  - 0x104's response is dropped; `if_id_valid`=0.
  - Next `imem_addr`=0x200.
- Stall on the response cycle: `stall_en`=1 for 4 cycles as 0x108's data returns.
  - IF/ID holds the 0x104 instruction throughout; no `imem_req`.
  - The cycle after `stall_en` drops, IF/ID = {1, 0x108, data}.
- `branch` and `stall_en` both high while HELD:
  - Skid buffer discarded; `if_id_valid`=0.
  - Once the stall clears, the first request goes to the target.
- Same-cycle `branch` and `imem_rvalid` in WAIT: the response is dropped; `kill` stays 0; the next request goes to the target one cycle later.
- Wrap and reset:
  - PC=0xFFFF_FFFC fetch, then next `imem_addr`=0x0.
  - Assert `rst` while WAIT: outputs reset immediately; a late `imem_rvalid` does not load IF/ID.
